ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline: takes decoded operands and control from the ID/EX boundary, computes the ALU result, and registers the EX/MEM pipeline outputs consumed directly by `mem_stage`. It contains an iterative 32-cycle radix-2 divider for DIV/DIVU/REM/REMU. While a divide is in flight, the divider stalls the front of the pipeline and injects bubbles into MEM.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset; single clock domain
- `rs1_data_id`  in  XLEN  operand A, already forwarded
- `rs2_data_id`  in  XLEN  operand B / store data, already forwarded
- `imm_id`  in  XLEN  sign-extended immediate
- `alu_src_id`  in  1  1 = B operand is `imm_id`
- `alu_op_id`  in  4  operation code (`alu_op_t`)
- `rd_addr_id`  in  5  destination register
- `mem_read_id`, `mem_write_id`, `reg_write_id`, `mem_to_reg_id`  in  1 each  control signals
- `flush_ex`  in  1  kill the instruction in EX, including any active divide
- `alu_result_ex`  out  XLEN  registered result or memory address
- `write_data_ex`  out  XLEN  registered `rs2_data_id`
- `rd_addr_ex`  out  5  registered destination
- `mem_read_ex`, `mem_write_ex`, `reg_write_ex`, `mem_to_reg_ex`  out  1 each  registered control signals
- `stall_ex`  out  1  combinational; high means PC, IF/ID and ID/EX must hold

## Operation
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount is B[4:0]), SLT, SLTU, PASSB (LUI), DIV, DIVU, REM, REMU. Undefined codes produce 0.
- Single-cycle ops: result is computed combinationally and registered with the control signals at the next `clk` edge.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when a div-class op is present, `flush_ex`=0, and the fast path does not apply. On this transition, load absolute-value operands and record the sign flags; count=0.
  - BUSY: one restoring shift-subtract step per cycle. At count==31, go to DONE.
  - DONE: apply signs (quotient negative iff the operand signs differ on signed ops; remainder takes the dividend's sign). Go to IDLE.
- Fast path, no stall: divide by zero gives quotient 0xFFFFFFFF and remainder = dividend. Signed 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
- `stall_ex` = div op in EX and (state IDLE entering BUSY, or state BUSY). It is low in DONE.
- While `stall_ex`=1, EX/MEM captures a bubble: `reg_write_ex`, `mem_read_ex`, `mem_write_ex`, `mem_to_reg_ex` = 0, and `rd_addr_ex` = 0.
- `flush_ex`=1: EX/MEM captures a bubble, FSM returns to IDLE, and `stall_ex` is forced to 0 in the same cycle.

## Timing
- Reset: all outputs are 0, FSM is IDLE, and `stall_ex` is 0.
- Non-div op: latency 1 cycle, throughput 1 per cycle.
- Normal div op:
  - Issue cycle T0: `stall_ex`=1.
  - T1..T32: BUSY, `stall_ex`=1.
  - T33: DONE, `stall_ex`=0; the result is captured at the end of T33.
  - The op occupies EX for 34 cycles; ID/EX inputs must stay stable over T0..T33.
- Reset asserted mid-divide: aborts immediately; no partial result is ever written.
- `rd_addr_id`=0 passes through unchanged; suppressing writes to x0 is the register file's job.

## Configuration
- `EX_DIV_EN` defined: divider FSM, fast path and stall logic are present.
- `EX_DIV_EN` undefined:
  - Div-class ops produce result 0 in one cycle.
  - `stall_ex` is tied to 0 and no divider state exists.

## Structure
- Shared package `core_pkg`:
  - `alu_op_t` enum (4-bit codes, ADD=0 … REMU=14).
  - `div_state_t` enum.
  - `XLEN` constant.
- Sub-module `ex_divider` holds the FSM, counter, remainder/quotient registers and sign fix-up. Its interface is `start`, `is_signed`, `want_rem`, `a`, `b`, `abort`, `busy`, `done`, `result`.
- The ALU and EX/MEM register stay in `ex_stage`.

## Test plan
- ADD with rs1=5, imm=-8, `alu_src_id`=1 → next cycle `alu_result_ex`=0xFFFFFFFD; `stall_ex` never asserts.
- DIV with rs1=-7, rs2=2:
  - `stall_ex` is high for exactly 33 cycles.
  - `alu_result_ex`=0xFFFFFFFD with `reg_write_ex`=1 one cycle after the stall drops.
  - Bubbles (`reg_write_ex`=0) are present throughout the stall.
- REMU with rs1=100, rs2=0 → no stall; the next cycle gives `alu_result_ex`=100.
- DIV with rs1=0x80000000, rs2=0xFFFFFFFF → no stall; result 0x80000000. The matching REM gives 0.
- DIVU 1000/7, with `flush_ex` pulsed at BUSY count 10 → `stall_ex` drops that cycle and a bubble is captured. A following ADD completes normally in 1 cycle.
- DIV in flight, `rst_n` pulsed low at BUSY count 5 → all outputs read 0 and the FSM is IDLE. After release, a fresh DIVU 1000/7 yields 142 after 33 stall cycles.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: ALU operation codes, divider FSM states and datapath width.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_DIV   = 4'd11,
    ALU_DIVU  = 4'd12,
    ALU_REM   = 4'd13,
    ALU_REMU  = 4'd14
  } alu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative 32-step restoring divider on operand magnitudes with sign fix-up in DONE.
module ex_divider
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_t      state, state_next;
  logic [4:0]      count;
  logic [XLEN-1:0] rem, quo, dvsr;
  logic            neg_q, neg_r, rem_sel;
  logic            step_ge;
  logic [XLEN-1:0] step_diff;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start) state_next = DIV_BUSY;
        DIV_BUSY: if (count == 5'd31) state_next = DIV_DONE;
        DIV_DONE: state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  // Shifted partial remainder can reach 33 bits; the difference itself always fits in 32.
  always_comb begin
    step_ge   = {rem, quo[XLEN-1]} >= {1'b0, dvsr};
    step_diff = {rem[XLEN-2:0], quo[XLEN-1]} - dvsr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DIV_IDLE;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
    end else begin
      state <= state_next;
      if (!abort) begin
        if (state == DIV_IDLE && start) begin
          rem     <= '0;
          quo     <= (is_signed && a[XLEN-1]) ? -a : a;
          dvsr    <= (is_signed && b[XLEN-1]) ? -b : b;
          neg_q   <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
          neg_r   <= is_signed && a[XLEN-1];
          rem_sel <= want_rem;
          count   <= '0;
        end else if (state == DIV_BUSY) begin
          rem   <= step_ge ? step_diff : {rem[XLEN-2:0], quo[XLEN-1]};
          quo   <= {quo[XLEN-2:0], step_ge};
          count <= count + 5'd1;
        end
      end
    end
  end

  always_comb begin
    quo_fix = neg_q ? -quo : quo;
    rem_fix = neg_r ? -rem : rem;
    result  = rem_sel ? rem_fix : quo_fix;
    busy    = (state == DIV_BUSY);
    done    = (state == DIV_DONE);
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, optional iterative divider (enabled by EX_DIV_EN) and EX/MEM register.
module ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rs1_data_id,
  input  logic [XLEN-1:0] rs2_data_id,
  input  logic [XLEN-1:0] imm_id,
  input  logic            alu_src_id,
  input  logic [3:0]      alu_op_id,
  input  logic [4:0]      rd_addr_id,
  input  logic            mem_read_id,
  input  logic            mem_write_id,
  input  logic            reg_write_id,
  input  logic            mem_to_reg_id,
  input  logic            flush_ex,
  output logic [XLEN-1:0] alu_result_ex,
  output logic [XLEN-1:0] write_data_ex,
  output logic [4:0]      rd_addr_ex,
  output logic            mem_read_ex,
  output logic            mem_write_ex,
  output logic            reg_write_ex,
  output logic            mem_to_reg_ex,
  output logic            stall_ex
);

  alu_op_t         op;
  logic [XLEN-1:0] op_a, op_b, alu_res, div_res;
  logic            bubble;

  assign op   = alu_op_t'(alu_op_id);
  assign op_a = rs1_data_id;
  assign op_b = alu_src_id ? imm_id : rs2_data_id;

`ifdef EX_DIV_EN
  logic            div_op, div_signed, div_rem, div_zero, div_ovf, fast;
  logic            div_busy, div_done, div_idle;
  logic [XLEN-1:0] div_result, fast_res;

  always_comb begin
    div_op     = is_div_op(op);
    div_signed = (op == ALU_DIV) || (op == ALU_REM);
    div_rem    = (op == ALU_REM) || (op == ALU_REMU);
    div_zero   = (op_b == '0);
    div_ovf    = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast       = div_zero || div_ovf;
    if (div_zero) fast_res = div_rem ? op_a : '1;
    else          fast_res = div_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    div_idle   = !div_busy && !div_done;
    stall_ex   = div_op && !flush_ex && (div_busy || (div_idle && !fast));
    div_res    = fast ? fast_res : (div_done ? div_result : '0);
  end

  ex_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_op && !fast && !flush_ex),
    .is_signed (div_signed),
    .want_rem  (div_rem),
    .a         (op_a),
    .b         (op_b),
    .abort     (flush_ex),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );
`else
  assign stall_ex = 1'b0;
  assign div_res  = '0;
`endif

  assign bubble = stall_ex || flush_ex;

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB: alu_res = op_b;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = div_res;
      default:   alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_ex <= '0;
      write_data_ex <= '0;
      rd_addr_ex    <= '0;
      mem_read_ex   <= 1'b0;
      mem_write_ex  <= 1'b0;
      reg_write_ex  <= 1'b0;
      mem_to_reg_ex <= 1'b0;
    end else begin
      alu_result_ex <= alu_res;
      write_data_ex <= rs2_data_id;
      rd_addr_ex    <= bubble ? 5'd0 : rd_addr_id;
      mem_read_ex   <= !bubble && mem_read_id;
      mem_write_ex  <= !bubble && mem_write_id;
      reg_write_ex  <= !bubble && reg_write_id;
      mem_to_reg_ex <= !bubble && mem_to_reg_id;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; divide expectations follow the EX_DIV_EN build option.
module tb_ex_stage;
  import core_pkg::*;

`ifdef EX_DIV_EN
  localparam int   DIV_STALL = 33;
  localparam logic DIV_ON    = 1'b1;
`else
  localparam int   DIV_STALL = 0;
  localparam logic DIV_ON    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rs1_data_id, rs2_data_id, imm_id;
  logic        alu_src_id;
  logic [3:0]  alu_op_id;
  logic [4:0]  rd_addr_id;
  logic        mem_read_id, mem_write_id, reg_write_id, mem_to_reg_id, flush_ex;
  logic [31:0] alu_result_ex, write_data_ex;
  logic [4:0]  rd_addr_ex;
  logic        mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex, stall_ex;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .alu_src_id(alu_src_id), .alu_op_id(alu_op_id), .rd_addr_id(rd_addr_id),
    .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
    .reg_write_id(reg_write_id), .mem_to_reg_id(mem_to_reg_id),
    .flush_ex(flush_ex),
    .alu_result_ex(alu_result_ex), .write_data_ex(write_data_ex), .rd_addr_ex(rd_addr_ex),
    .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
    .stall_ex(stall_ex)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic [4:0] rd);
    alu_op_id     = op;
    rs1_data_id   = a;
    rs2_data_id   = b;
    imm_id        = imm;
    alu_src_id    = src;
    rd_addr_id    = rd;
    reg_write_id  = 1'b1;
    mem_read_id   = 1'b0;
    mem_write_id  = 1'b0;
    mem_to_reg_id = 1'b0;
  endtask

  task automatic clear_inputs();
    drive(ALU_ADD, '0, '0, '0, 1'b0, 5'd0);
    reg_write_id = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res"}, alu_result_ex, 32'h0);
    check({tag, "_wd"}, write_data_ex, 32'h0);
    check({tag, "_ctl"}, {23'b0, rd_addr_ex, mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex}, 32'h0);
    check({tag, "_stall"}, {31'b0, stall_ex}, 32'h0);
  endtask

  task automatic alu_step(input string tag, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b, '0, 1'b0, 5'd7);
    #1;
    check({tag, "_stall"}, {31'b0, stall_ex}, 32'h0);
    tick();
    check(tag, alu_result_ex, exp);
    check({tag, "_rd"}, {27'b0, rd_addr_ex}, 32'd7);
  endtask

  task automatic run_div(input string tag, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall, input logic [31:0] exp);
    int n;
    drive(op, a, b, '0, 1'b0, 5'd5);
    #1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (!stall_ex) break;
      n++;
      tick();
      check({tag, "_bubble"}, {26'b0, rd_addr_ex, reg_write_ex}, 32'h0);
    end
    check({tag, "_stalls"}, n, exp_stall);
    tick();
    check(tag, alu_result_ex, exp);
    check({tag, "_rw"}, {31'b0, reg_write_ex}, 32'h1);
    check({tag, "_rd"}, {27'b0, rd_addr_ex}, 32'd5);
  endtask

  initial begin
    rst_n    = 1'b0;
    flush_ex = 1'b0;
    clear_inputs();
    tick();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 5 + (-8) via immediate
    drive(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFF8, 1'b1, 5'd3);
    #1;
    check("add_stall", {31'b0, stall_ex}, 32'h0);
    tick();
    check("add_imm", alu_result_ex, 32'hFFFF_FFFD);
    check("add_rw", {31'b0, reg_write_ex}, 32'h1);
    check("add_rd", {27'b0, rd_addr_ex}, 32'd3);

    alu_step("sub",   ALU_SUB,   32'd10,          32'd3,          32'd7);
    alu_step("and",   ALU_AND,   32'hF0F0_1234,   32'h0FF0_FF00,  32'h00F0_1200);
    alu_step("xor",   ALU_XOR,   32'hAAAA_5555,   32'hFFFF_0000,  32'h5555_5555);
    alu_step("sll",   ALU_SLL,   32'h0000_0003,   32'h0000_0024,  32'h0000_0030);
    alu_step("srl",   ALU_SRL,   32'h8000_0000,   32'd4,          32'h0800_0000);
    alu_step("sra",   ALU_SRA,   32'h8000_0000,   32'd4,          32'hF800_0000);
    alu_step("slt",   ALU_SLT,   32'hFFFF_FFFF,   32'd1,          32'd1);
    alu_step("sltu",  ALU_SLTU,  32'hFFFF_FFFF,   32'd1,          32'd0);
    alu_step("passb", ALU_PASSB, 32'd9,           32'h1234_5000,  32'h1234_5000);
    alu_step("undef", alu_op_t'(4'd15), 32'd9,    32'd9,          32'd0);

    // store-style control passthrough
    drive(ALU_ADD, 32'h100, 32'hDEAD_BEEF, 32'd4, 1'b1, 5'd0);
    reg_write_id = 1'b0;
    mem_write_id = 1'b1;
    tick();
    check("sw_addr", alu_result_ex, 32'h104);
    check("sw_data", write_data_ex, 32'hDEAD_BEEF);
    check("sw_ctl", {28'b0, mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex}, 32'b0100);

    run_div("div_neg",  ALU_DIV,  32'hFFFF_FFF9, 32'd2,          DIV_STALL, DIV_ON ? 32'hFFFF_FFFD : 32'h0);
    run_div("rem_neg",  ALU_REM,  32'hFFFF_FFF9, 32'd2,          DIV_STALL, DIV_ON ? 32'hFFFF_FFFF : 32'h0);
    run_div("remu_z",   ALU_REMU, 32'd100,       32'd0,          0,         DIV_ON ? 32'd100 : 32'h0);
    run_div("divu_z",   ALU_DIVU, 32'd100,       32'd0,          0,         DIV_ON ? 32'hFFFF_FFFF : 32'h0);
    run_div("div_ovf",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0,         DIV_ON ? 32'h8000_0000 : 32'h0);
    run_div("rem_ovf",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0,         32'h0);

    // DIVU 1000/7 flushed at BUSY count 10 (cycle T11)
    drive(ALU_DIVU, 32'd1000, 32'd7, '0, 1'b0, 5'd5);
    for (int i = 0; i < 11; i++) tick();
    check("flush_pre_stall", {31'b0, stall_ex}, {31'b0, DIV_ON});
    flush_ex = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall_ex}, 32'h0);
    tick();
    check("flush_bubble", {26'b0, rd_addr_ex, reg_write_ex}, 32'h0);
    flush_ex = 1'b0;
    drive(ALU_ADD, 32'd2, 32'd3, '0, 1'b0, 5'd9);
    #1;
    check("post_flush_stall", {31'b0, stall_ex}, 32'h0);
    tick();
    check("post_flush_add", alu_result_ex, 32'd5);
    check("post_flush_rd", {27'b0, rd_addr_ex}, 32'd9);

    // reset pulsed at BUSY count 5 (cycle T6)
    drive(ALU_DIV, 32'hFFFF_FFF9, 32'd2, '0, 1'b0, 5'd5);
    for (int i = 0; i < 6; i++) tick();
    check("prereset_wd", write_data_ex, 32'd2);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_div("divu_after_rst", ALU_DIVU, 32'd1000, 32'd7, DIV_STALL, DIV_ON ? 32'd142 : 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
